// File: rtl/mul_pipe_if.sv
// mul_pipe_if: issue/result/hazard-query bundle between the EX stage and mul_pipe_unit.
interface mul_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             stall_i;
  logic             flush_i;
  logic             in_valid_i;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  opa_i;
  logic [XLEN-1:0]  opb_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;
  logic [TAG_W-1:0] chk_tag_i;
  logic             chk_hit_o;
  modport master (
    output stall_i, flush_i, in_valid_i, op_i, opa_i, opb_i, tag_i, chk_tag_i,
    input  out_valid_o, result_o, tag_o, busy_o, chk_hit_o
  );
  modport slave (
    input  stall_i, flush_i, in_valid_i, op_i, opa_i, opb_i, tag_i, chk_tag_i,
    output out_valid_o, result_o, tag_o, busy_o, chk_hit_o
  );
endinterface

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: stallable, flushable RV32M multiplier with STAGES-cycle latency and in-flight tag check.
// Optional MUL_PIPE_STAT_EN adds accepted-op and flush-kill counters.
module mul_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_pipe_if.slave   bus
`ifdef MUL_PIPE_STAT_EN
  ,
  output logic [31:0] op_cnt_o,
  output logic [31:0] flush_kill_cnt_o
`endif
);
  logic                acc;
  logic                sa;
  logic                sb;
  logic [2*XLEN-1:0]   a_x;
  logic [2*XLEN-1:0]   b_x;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     res;
  logic [STAGES-1:0]   v_q, v_d;
  logic [XLEN-1:0]     d_q [STAGES];
  logic [XLEN-1:0]     d_d [STAGES];
  logic [TAG_W-1:0]    t_q [STAGES];
  logic [TAG_W-1:0]    t_d [STAGES];
  logic                hit;
  // Low 2*XLEN bits of the extended product are exact modulo 2^(2*XLEN), which covers both halves.
  always_comb begin
    acc  = bus.in_valid_i & ~bus.stall_i & ~bus.flush_i;
    sa   = bus.op_i != 2'b11;
    sb   = ~bus.op_i[1];
    a_x  = {{XLEN{sa & bus.opa_i[XLEN-1]}}, bus.opa_i};
    b_x  = {{XLEN{sb & bus.opb_i[XLEN-1]}}, bus.opb_i};
    prod = a_x * b_x;
    res  = bus.op_i == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    t_d = t_q;
    if (!bus.stall_i) begin
      v_d[0] = acc;
      d_d[0] = res;
      t_d[0] = bus.tag_i;
      for (int s = 1; s < STAGES; s++) begin
        v_d[s] = v_q[s-1];
        d_d[s] = d_q[s-1];
        t_d[s] = t_q[s-1];
      end
    end
    if (bus.flush_i) v_d = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
      t_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      t_q <= t_d;
    end
  end
  // The final stage is forwarded by MEM/WB, so only earlier stages raise a hazard.
  always_comb begin
    hit = 1'b0;
    for (int s = 0; s < STAGES - 1; s++)
      if (v_q[s] && t_q[s] == bus.chk_tag_i && bus.chk_tag_i != '0) hit = 1'b1;
  end
  assign bus.out_valid_o = v_q[STAGES-1];
  assign bus.result_o    = d_q[STAGES-1];
  assign bus.tag_o       = t_q[STAGES-1];
  assign bus.busy_o      = |v_q;
  assign bus.chk_hit_o   = hit;
`ifdef MUL_PIPE_STAT_EN
  logic [31:0] op_cnt_q;
  logic [31:0] fk_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
      fk_cnt_q <= '0;
    end else begin
      if (acc) op_cnt_q <= op_cnt_q + 32'd1;
      if (bus.flush_i && |v_q) fk_cnt_q <= fk_cnt_q + 32'd1;
    end
  end
  assign op_cnt_o         = op_cnt_q;
  assign flush_kill_cnt_o = fk_cnt_q;
`endif
endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: drives STAGES=1..4 instances in lockstep, scoreboard checks results, latency, busy and hazard hits.
module tb_mul_pipe_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] opa = '0, opb = '0;
  logic [4:0]  tag = '0, chk_tag = '0;
  logic [3:0]        ov, busy, hit;
  logic [3:0][31:0]  res;
  logic [3:0][4:0]   tg;
`ifdef MUL_PIPE_STAT_EN
  logic [3:0][31:0]  opc, fkc;
`endif
  typedef struct {
    logic [31:0] r;
    logic [4:0]  t;
    int          cyc;
    int          st;
  } exp_t;
  exp_t q[4][$];
  int cyc = 0, st = 0, checks = 0, passed = 0, n_acc = 0;
  int n_fk[4] = '{default: 0};
  for (genvar g = 0; g < 4; g++) begin : gd
    mul_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();
    assign bus.stall_i    = stall;
    assign bus.flush_i    = flush;
    assign bus.in_valid_i = in_valid;
    assign bus.op_i       = op;
    assign bus.opa_i      = opa;
    assign bus.opb_i      = opb;
    assign bus.tag_i      = tag;
    assign bus.chk_tag_i  = chk_tag;
    assign ov[g]   = bus.out_valid_o;
    assign res[g]  = bus.result_o;
    assign tg[g]   = bus.tag_o;
    assign busy[g] = bus.busy_o;
    assign hit[g]  = bus.chk_hit_o;
    mul_pipe_unit #(.XLEN(32), .STAGES(g + 1), .TAG_W(5)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef MUL_PIPE_STAT_EN
      ,
      .op_cnt_o(opc[g]),
      .flush_kill_cnt_o(fkc[g])
`endif
    );
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Reference: sign/zero-extend to 64 bits and multiply with plain integer arithmetic.
  function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint x, y, p;
    x = (o == 2'b11) ? longint'({32'b0, a}) : longint'(signed'(a));
    y = o[1] ? longint'({32'b0, b}) : longint'(signed'(b));
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  // Effective pipeline age: edges since acceptance minus edges spent frozen by stall.
  function automatic int age(exp_t e);
    return (cyc - e.cyc) - (st - e.st);
  endfunction
  task automatic step(logic v, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] t,
                      logic s, logic f, logic [31:0] er);
    logic kill[4];
    #1;
    in_valid = v; op = o; opa = a; opb = b; tag = t; stall = s; flush = f;
    for (int k = 0; k < 4; k++) kill[k] = f && q[k].size() > 0;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin q[k].delete(); n_fk[k] = 0; end
      n_acc = 0;
    end else if (f) begin
      for (int k = 0; k < 4; k++) begin q[k].delete(); if (kill[k]) n_fk[k]++; end
    end else if (s) begin
      st++;
    end else if (v) begin
      for (int k = 0; k < 4; k++) q[k].push_back('{r: er, t: t, cyc: cyc, st: st});
      n_acc++;
    end
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic check_zero(string name);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s out_valid s%0d", name, k + 1), {31'b0, ov[k]}, 32'd0);
      chk($sformatf("%s result s%0d", name, k + 1), res[k], 32'd0);
      chk($sformatf("%s tag s%0d", name, k + 1), {27'b0, tg[k]}, 32'd0);
      chk($sformatf("%s busy s%0d", name, k + 1), {31'b0, busy[k]}, 32'd0);
      chk($sformatf("%s hit s%0d", name, k + 1), {31'b0, hit[k]}, 32'd0);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        logic eh;
        eh = 1'b0;
        for (int i = 0; i < q[k].size(); i++)
          if (age(q[k][i]) < k && q[k][i].t == chk_tag && chk_tag != 5'd0) eh = 1'b1;
        chk($sformatf("chk_hit s%0d tag %0d", k + 1, chk_tag), {31'b0, hit[k]}, {31'b0, eh});
        chk($sformatf("busy s%0d", k + 1), {31'b0, busy[k]}, {31'b0, q[k].size() > 0});
        if (ov[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            $display("FAIL spurious output s%0d: got tag %0d result %h expected no output", k + 1, tg[k], res[k]);
          end else begin
            chk($sformatf("latency s%0d", k + 1), age(q[k][0]) + 1, k + 1);
            chk($sformatf("result s%0d", k + 1), res[k], q[k][0].r);
            chk($sformatf("tag s%0d", k + 1), {27'b0, tg[k]}, {27'b0, q[k][0].t});
            if (!stall || flush) void'(q[k].pop_front());
          end
        end else if (q[k].size() > 0 && age(q[k][0]) >= k) begin
          checks++;
          $display("FAIL missing output s%0d: got out_valid 0 expected tag %0d", k + 1, q[k][0].t);
        end
      end
    end
  end
  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(0, 3);
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    idle(2);
    check_zero("reset");
    rst_n = 1'b1;
    step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0, 32'hFFFF_FFFE);
    step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b0, 32'h0000_0001);
    step(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 1'b0, 32'h0000_0000);
    step(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd11, 1'b0, 1'b0, 32'h4000_0000);
    idle(5);
    step(1'b1, 2'b00, 32'd3, 32'd5, 5'd1, 1'b0, 1'b0, 32'd15);
    step(1'b1, 2'b00, 32'd6, 32'd7, 5'd2, 1'b0, 1'b0, 32'd42);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'd9, 32'd9, 5'd3, 1'b1, 1'b0, 32'd81);
    idle(5);
    step(1'b1, 2'b00, 32'd2, 32'd2, 5'd4, 1'b0, 1'b0, 32'd4);
    step(1'b1, 2'b00, 32'd2, 32'd3, 5'd5, 1'b0, 1'b0, 32'd6);
    step(1'b1, 2'b00, 32'd2, 32'd4, 5'd6, 1'b1, 1'b1, 32'd8);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("flush busy s%0d", k + 1), {31'b0, busy[k]}, 32'd0);
      chk($sformatf("flush out_valid s%0d", k + 1), {31'b0, ov[k]}, 32'd0);
    end
    idle(3);
    chk_tag = 5'd5;
    step(1'b1, 2'b11, 32'd10, 32'd20, 5'd5, 1'b0, 1'b0, 32'd0);
    idle(5);
    chk_tag = 5'd0;
    step(1'b1, 2'b00, 32'd10, 32'd20, 5'd0, 1'b0, 1'b0, 32'd200);
    idle(5);
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      if (i == 700) begin
        rst_n = 1'b0;
        step(1'b1, 2'b00, 32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 32'd1);
        check_zero("mid reset");
        rst_n = 1'b1;
      end
      o = 2'($urandom_range(0, 3));
      a = rnd_opnd();
      b = rnd_opnd();
      chk_tag = 5'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, o, a, b, 5'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, ref_mul(o, a, b));
    end
    for (int i = 0; i < 20; i++) idle(1);
    for (int k = 0; k < 4; k++) chk($sformatf("drained s%0d", k + 1), q[k].size(), 32'd0);
`ifdef MUL_PIPE_STAT_EN
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("op_cnt s%0d", k + 1), opc[k], n_acc);
      chk($sformatf("flush_kill_cnt s%0d", k + 1), fkc[k], n_fk[k]);
    end
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
